// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and constants for the 4-way round-robin mux arbiter
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_REQ          = 4;
  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick: first set req bit at ptr, ptr+1, ptr+2, ptr+3
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_ptr,
  output logic             o_valid,
  output logic [1:0]       o_idx
);

  logic [1:0] w_cand;

  // Scan from the farthest offset down so the nearest set bit overrides.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = i_ptr;
    w_cand  = i_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = i_ptr + 2'(k);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arb.sv
// rtl/rr_mux4_arb.sv - 4-requester round-robin burst arbiter with registered muxed output
module rr_mux4_arb
  import rr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] d_in0,
  input  logic [DATA_WIDTH-1:0] d_in1,
  input  logic [DATA_WIDTH-1:0] d_in2,
  input  logic [DATA_WIDTH-1:0] d_in3,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      ack,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [1:0]            sel,
  output logic                  busy
);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [1:0]            r_ptr;
  logic [1:0]            w_ptr_nxt;
  logic [1:0]            r_sel;
  logic [1:0]            w_sel_nxt;
  logic [3:0]            r_beat_cnt;
  logic [3:0]            w_beat_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_y;
  logic                  r_y_valid;

  logic                  w_pick_valid;
  logic [1:0]            w_pick_idx;
  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_last_beat;
  logic [DATA_WIDTH-1:0] w_mux;

  rr_pick4 u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_out_free  = !r_y_valid || y_ready;
  assign w_accept    = (r_state == GRANT) && req[r_sel] && w_out_free;
  assign w_last_beat = (r_beat_cnt == 4'(BURST_MAX - 1));

  always_comb begin
    w_mux = d_in0;
    case (r_sel)
      2'd0:    w_mux = d_in0;
      2'd1:    w_mux = d_in1;
      2'd2:    w_mux = d_in2;
      default: w_mux = d_in3;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_sel_nxt      = r_sel;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt    = GRANT;
          w_sel_nxt      = w_pick_idx;
          w_beat_cnt_nxt = 4'd0;
        end
      end
      default: begin
        if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + 4'd1;
        end
        // A dropped request ends the burst early; the next scan starts past the holder.
        if ((w_accept && w_last_beat) || !req[r_sel]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_sel + 2'd1;
          w_sel_nxt   = 2'd0;
        end
      end
    endcase
  end

  always_comb begin
    ack = '0;
    if (w_accept) begin
      ack[r_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_sel      <= 2'd0;
      r_beat_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sel      <= w_sel_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Output register drains independently of the FSM, so a release never drops a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else if (w_accept) begin
      r_y       <= w_mux;
      r_y_valid <= 1'b1;
    end else if (r_y_valid && y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign sel     = r_sel;
  assign busy    = (r_state == GRANT);

endmodule

// File: tb/tb_rr_mux4_arb.sv
// tb/tb_rr_mux4_arb.sv - directed scoreboard bench for rr_mux4_arb (BURST_MAX 4 and 1)
module tb_rr_mux4_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] req, req1;
  logic       y_ready;

  logic [3:0] ack_a, ack_b;
  logic [7:0] y_a, y_b;
  logic       yv_a, yv_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b;

  int n_vec  = 0;
  int n_fail = 0;

  int         q_ack_a[$];
  int         q_ack_b[$];
  logic [7:0] q_y_a[$];
  logic [7:0] q_y_b[$];

  always #5 clk = ~clk;

  rr_mux4_arb #(.DATA_WIDTH(8), .BURST_MAX(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .d_in0(d0), .d_in1(d1), .d_in2(d2), .d_in3(d3),
    .req(req), .ack(ack_a), .y(y_a), .y_valid(yv_a), .y_ready(y_ready),
    .sel(sel_a), .busy(busy_a)
  );

  rr_mux4_arb #(.DATA_WIDTH(8), .BURST_MAX(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .d_in0(d0), .d_in1(d1), .d_in2(d2), .d_in3(d3),
    .req(req1), .ack(ack_b), .y(y_b), .y_valid(yv_b), .y_ready(y_ready),
    .sel(sel_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input int idx, input int n);
    repeat (n) begin
      q_ack_a.push_back(idx);
      q_y_a.push_back(8'hA0 + 8'(idx));
    end
  endtask

  task automatic expect_b(input int idx);
    q_ack_b.push_back(idx);
    q_y_b.push_back(8'hA0 + 8'(idx));
  endtask

  always @(negedge clk) begin : mon_a
    int e;
    if (ack_a !== 4'b0000) begin
      if (q_ack_a.size() == 0) check("ack_a_unexpected", 32'(ack_a), 32'h0);
      else begin
        e = q_ack_a.pop_front();
        check("ack_a", 32'(ack_a), 32'h1 << e);
      end
    end
    if (yv_a === 1'b1 && y_ready === 1'b1) begin
      if (q_y_a.size() == 0) check("y_a_unexpected", 32'(y_a), 32'hFFFF);
      else check("y_a", 32'(y_a), 32'(q_y_a.pop_front()));
    end
  end

  always @(negedge clk) begin : mon_b
    int e;
    if (ack_b !== 4'b0000) begin
      if (q_ack_b.size() == 0) check("ack_b_unexpected", 32'(ack_b), 32'h0);
      else begin
        e = q_ack_b.pop_front();
        check("ack_b", 32'(ack_b), 32'h1 << e);
      end
    end
    if (yv_b === 1'b1 && y_ready === 1'b1) begin
      if (q_y_b.size() == 0) check("y_b_unexpected", 32'(y_b), 32'hFFFF);
      else check("y_b", 32'(y_b), 32'(q_y_b.pop_front()));
    end
  end

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    req1    = 4'b0000;
    y_ready = 1'b1;
    d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;
    step(2);
    @(negedge clk);
    check("rst_ack",  32'(ack_a),  32'h0);
    check("rst_y",    32'(y_a),    32'h0);
    check("rst_yv",   32'(yv_a),   32'h0);
    check("rst_sel",  32'(sel_a),  32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);

    // All four requesting: bursts of four in order 0,1,2,3 with an idle gap.
    expect_a(0, 4); expect_a(1, 4); expect_a(2, 4); expect_a(3, 4);
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t1_busy", 32'((c % 5) != 0), 32'(busy_a));
      check("t1_sel", 32'(sel_a), ((c % 5) != 0) ? 32'(c / 5) : 32'h0);
      @(posedge clk); #1;
    end
    req = 4'b0000;
    step(3);
    check("t1_drain_ack", 32'(q_ack_a.size()), 32'h0);
    check("t1_drain_y",   32'(q_y_a.size()),   32'h0);

    // Short burst ended by dropping req[2]; pointer moves to 3.
    expect_a(2, 2);
    req = 4'b0100;
    step(3);
    req = 4'b0000;
    step(1);
    @(negedge clk);
    check("t2_released", 32'(busy_a), 32'h0);
    @(posedge clk); #1;

    // Pointer at 3 with req 1001: grant 3, then wrap to 0.
    expect_a(3, 4); expect_a(0, 4);
    req = 4'b1001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_busy", 32'(busy_a), 32'((c % 5) != 0));
      check("t4_sel", 32'(sel_a), ((c % 5) == 0) ? 32'h0 : ((c < 5) ? 32'h3 : 32'h0));
      @(posedge clk); #1;
    end
    req = 4'b0000;
    step(3);
    check("t4_drain", 32'(q_ack_a.size()), 32'h0);

    // Backpressure on requester 1 after its first beat.
    expect_a(1, 4);
    req = 4'b0010;
    step(2);
    y_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_hold_ack", 32'(ack_a), 32'h0);
      check("t3_hold_y",   32'(y_a),   32'hA1);
      check("t3_hold_yv",  32'(yv_a),  32'h1);
      @(posedge clk); #1;
    end
    y_ready = 1'b1;
    step(3);
    req = 4'b0000;
    step(2);
    check("t3_drain", 32'(q_y_a.size()), 32'h0);

    // Reset mid-burst with a beat pending: everything clears at once.
    q_ack_a.push_back(2); q_ack_a.push_back(2);
    q_y_a.push_back(8'hA2);
    req = 4'b1111;
    step(3);
    rst_n = 1'b0;
    #1;
    check("t5_ack",  32'(ack_a),  32'h0);
    check("t5_y",    32'(y_a),    32'h0);
    check("t5_yv",   32'(yv_a),   32'h0);
    check("t5_sel",  32'(sel_a),  32'h0);
    check("t5_busy", 32'(busy_a), 32'h0);
    check("t5_q",    32'(q_ack_a.size() + q_y_a.size()), 32'h0);
    req = 4'b0011;
    step(2);
    expect_a(0, 4); expect_a(1, 4);
    rst_n = 1'b1;
    step(10);
    req = 4'b0000;
    step(3);
    check("t5_drain", 32'(q_ack_a.size() + q_y_a.size()), 32'h0);

    // Single-beat bursts alternate between requesters 0 and 2.
    expect_b(0); expect_b(2); expect_b(0); expect_b(2);
    req1 = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t6_busy", 32'(busy_b), 32'(c % 2));
      @(posedge clk); #1;
    end
    req1 = 4'b0000;
    step(3);

    check("end_ack_a", 32'(q_ack_a.size()), 32'h0);
    check("end_y_a",   32'(q_y_a.size()),   32'h0);
    check("end_ack_b", 32'(q_ack_b.size()), 32'h0);
    check("end_y_b",   32'(q_y_b.size()),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
